// File: rtl/usb_tx_serializer_if.sv
// rtl/usb_tx_serializer_if.sv - packet-byte, encoder-handshake and status signals of the USB TX serializer
// The packet source/encoder side drives via master; the serializer attaches via slave.
interface usb_tx_serializer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       tx_data_ready;
    logic       tx_hold;
    logic       tx_out_bit;
    logic       tx_shift;
    logic       create_eop;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_start, tx_data, tx_data_valid, tx_last, tx_hold,
        input  tx_data_ready, tx_out_bit, tx_shift, create_eop, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_start, tx_data, tx_data_valid, tx_last, tx_hold,
        output tx_data_ready, tx_out_bit, tx_shift, create_eop, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - USB TX bit source: SYNC + LSB-first packet bytes, bit-timer paced, EOP request
// Stalls on encoder stuff requests (tx_hold) and flags underrun when the packet buffer runs dry.
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int EOP_CLKS     = 24
) (
    input  logic               clk,
    input  logic               rst,
    usb_tx_serializer_if.slave bus
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int EW = (EOP_CLKS > 1) ? $clog2(EOP_CLKS) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [EW-1:0] EOP_MAX   = EW'(EOP_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_TAIL,
        S_EOP_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic          eop_pulse_q, eop_pulse_d;
    logic [EW-1:0] eop_cnt_q, eop_cnt_d;

    logic          timer_end;
    logic          shift_c;
    logic          ready_c;
    logic          eop_c;
    logic          out_bit_c;

    assign timer_end = (timer_q == TIMER_MAX);
    assign shift_c   = timer_end &&
                       ((state_q == S_SYNC) || (state_q == S_DATA) || (state_q == S_TAIL));

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        last_d      = last_q;
        err_d       = err_q;
        eop_pulse_d = 1'b0;
        eop_cnt_d   = eop_cnt_q;
        ready_c     = 1'b0;
        eop_c       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.tx_start) begin
                    state_d = S_SYNC;
                    timer_d = '0;
                    idx_d   = 3'd0;
                    shift_d = 8'h80;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end

            S_SYNC, S_DATA: begin
                timer_d = timer_end ? '0 : timer_q + 1'b1;
                // A shift with tx_hold set is a stuff period: nothing advances.
                if (timer_end && !bus.tx_hold) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        if ((state_q == S_DATA) && last_q) begin
                            state_d = S_TAIL;
                        end else if (bus.tx_data_valid) begin
                            ready_c = 1'b1;
                            shift_d = bus.tx_data;
                            last_d  = bus.tx_last;
                            state_d = S_DATA;
                        end else begin
                            err_d       = 1'b1;
                            eop_pulse_d = 1'b1;
                            eop_cnt_d   = '0;
                            state_d     = S_EOP_WAIT;
                        end
                    end
                end
            end

            S_TAIL: begin
                // Timer is 0 only on the first TAIL cycle; a hold there means one
                // trailing stuffed bit must go out before EOP.
                if ((timer_q == '0) && !bus.tx_hold) begin
                    eop_c     = 1'b1;
                    eop_cnt_d = '0;
                    state_d   = S_EOP_WAIT;
                end else if (timer_end) begin
                    timer_d     = '0;
                    eop_pulse_d = 1'b1;
                    eop_cnt_d   = '0;
                    state_d     = S_EOP_WAIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_EOP_WAIT: begin
                if (eop_cnt_q == EOP_MAX) begin
                    state_d = S_DONE;
                end else begin
                    eop_cnt_d = eop_cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        out_bit_c = 1'b1;
        case (state_q)
            S_SYNC, S_DATA: out_bit_c = shift_q[0] & ~bus.tx_hold;
            S_TAIL:         out_bit_c = 1'b0;
            default:        out_bit_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            eop_pulse_q <= 1'b0;
            eop_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            err_q       <= err_d;
            eop_pulse_q <= eop_pulse_d;
            eop_cnt_q   <= eop_cnt_d;
        end
    end

    // Same-cycle strobes are masked while rst is high so an abort never leaks an EOP or a fetch.
    assign bus.tx_data_ready = ready_c & ~rst;
    assign bus.create_eop    = (eop_c | eop_pulse_q) & ~rst;
    assign bus.tx_shift      = shift_c;
    assign bus.tx_out_bit    = out_bit_c;
    assign bus.tx_busy       = (state_q != S_IDLE);
    assign bus.tx_done       = (state_q == S_DONE);
    assign bus.tx_error      = err_q;
endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb/tb_usb_tx_serializer.sv - scoreboard bench for usb_tx_serializer with an encoder stuff-counter model
module tb_usb_tx_serializer;
    localparam int CPB  = 8;
    localparam int EOPC = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    usb_tx_serializer_if bus();

    usb_tx_serializer #(.CLKS_PER_BIT(CPB), .EOP_CLKS(EOPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int rel      = 0;
    int nshift   = 0;
    int nstuff   = 0;
    int done_cnt = 0;
    int stray    = 0;
    bit sb_en    = 1'b1;

    int   exp_bits[$];
    int   exp_ready[$];
    int   exp_eop[$];
    int   exp_done[$];
    int   exp_nshift[$];
    int   exp_nstuff[$];
    int   exp_err[$];
    logic [7:0] feed_data[$];
    logic       feed_last[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Encoder model: six consecutive 1s -> the next bit period is a stuffed 0.
    int   ones = 0;
    logic hold = 1'b0;
    assign bus.tx_hold = hold;
    always @(posedge clk) begin
        if (rst) begin
            ones <= 0;
            hold <= 1'b0;
        end else if (bus.tx_shift) begin
            if (hold) begin
                hold <= 1'b0;
                ones <= 0;
            end else if (bus.tx_out_bit) begin
                if (ones == 5) begin
                    hold <= 1'b1;
                    ones <= 0;
                end else begin
                    ones <= ones + 1;
                end
            end else begin
                ones <= 0;
            end
        end else if (bus.create_eop) begin
            ones <= 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", name, act, exp, rel);
        end
    endtask

    task automatic fail_evt(input string name, input int act);
        checks++;
        failures++;
        $display("FAIL %s: got event at %0d expected none", name, act);
    endtask

    // Packet-buffer model: presents the head byte, pops it the negedge after a ready pulse.
    initial begin
        bit pop_pend;
        pop_pend = 1'b0;
        bus.tx_data       = 8'h00;
        bus.tx_data_valid = 1'b0;
        bus.tx_last       = 1'b0;
        forever begin
            @(negedge clk);
            if (pop_pend && feed_data.size() > 0) begin
                void'(feed_data.pop_front());
                void'(feed_last.pop_front());
            end
            pop_pend = bus.tx_data_ready && !rst;
            bus.tx_data_valid = (feed_data.size() > 0);
            bus.tx_data       = (feed_data.size() > 0) ? feed_data[0] : 8'h00;
            bus.tx_last       = (feed_last.size() > 0) ? feed_last[0] : 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        forever begin
            @(negedge clk);
            rel = cyc - t0;
            if (!rst && !sb_en) begin
                if (bus.create_eop || bus.tx_done || bus.tx_data_ready) stray++;
            end else if (!rst) begin
                if (bus.tx_shift) begin
                    nshift++;
                    if (bus.tx_hold) begin
                        nstuff++;
                        check("stuff_bit", int'(bus.tx_out_bit), 0);
                    end else if (exp_bits.size() == 0) begin
                        fail_evt("extra_bit", nshift);
                    end else begin
                        check("bit", int'(bus.tx_out_bit), exp_bits.pop_front());
                    end
                end
                if (bus.tx_data_ready) begin
                    if (exp_ready.size() == 0) fail_evt("unexpected_ready", nshift);
                    else check("ready_shift", nshift, exp_ready.pop_front());
                end
                if (bus.create_eop) begin
                    check("eop_no_shift", int'(bus.tx_shift), 0);
                    if (exp_eop.size() == 0) fail_evt("unexpected_eop", rel);
                    else check("eop_cycle", rel, exp_eop.pop_front());
                end
                if (bus.tx_done) begin
                    if (exp_done.size() == 0) begin
                        fail_evt("unexpected_done", rel);
                    end else begin
                        check("done_cycle", rel, exp_done.pop_front());
                        check("shift_count", nshift, exp_nshift.pop_front());
                        check("stuff_count", nstuff, exp_nstuff.pop_front());
                        check("error_flag", int'(bus.tx_error), exp_err.pop_front());
                        check("bits_left", exp_bits.size(), 0);
                        check("ready_left", exp_ready.size(), 0);
                        check("eop_left", exp_eop.size(), 0);
                    end
                    nshift = 0;
                    nstuff = 0;
                    done_cnt++;
                end
            end
        end
    end

    task automatic push_byte_bits(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_bits.push_back(int'(b[i]));
    endtask

    task automatic expect_pkt(input int eop, input int done, input int ns, input int nst, input int err);
        exp_eop.push_back(eop);
        exp_done.push_back(done);
        exp_nshift.push_back(ns);
        exp_nstuff.push_back(nst);
        exp_err.push_back(err);
    endtask

    task automatic feed(input logic [7:0] d, input logic l);
        feed_data.push_back(d);
        feed_last.push_back(l);
    endtask

    task automatic start_pkt();
        @(negedge clk);
        t0 = cyc;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  d0;
        bit  ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_evt({name, "_timeout"}, cyc - t0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pkt_single_00();
        push_byte_bits(8'h80);
        push_byte_bits(8'h00);
        exp_ready.push_back(8);
        expect_pkt(129, 154, 16, 0, 0);
        feed(8'h00, 1'b1);
        start_pkt();
        wait_done("single_00");
    endtask

    initial begin
        bus.tx_start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_bit", int'(bus.tx_out_bit), 1);
        check("rst_busy",    int'(bus.tx_busy), 0);
        check("rst_shift",   int'(bus.tx_shift), 0);
        check("rst_eop",     int'(bus.create_eop), 0);
        check("rst_done",    int'(bus.tx_done), 0);
        check("rst_error",   int'(bus.tx_error), 0);
        check("rst_ready",   int'(bus.tx_data_ready), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pkt_single_00();

        // Three back-to-back bytes, plus a tx_start mid-packet that must be ignored.
        push_byte_bits(8'h80);
        push_byte_bits(8'hA5);
        push_byte_bits(8'h3C);
        push_byte_bits(8'hC3);
        exp_ready.push_back(8);
        exp_ready.push_back(16);
        exp_ready.push_back(24);
        expect_pkt(257, 282, 32, 0, 0);
        feed(8'hA5, 1'b0);
        feed(8'h3C, 1'b0);
        feed(8'hC3, 1'b1);
        start_pkt();
        repeat (100) @(negedge clk);
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        wait_done("three_bytes");

        // 0xFF: stuff mid-byte after SYNC's final 1 plus five data 1s.
        push_byte_bits(8'h80);
        push_byte_bits(8'hFF);
        exp_ready.push_back(8);
        expect_pkt(137, 162, 17, 1, 0);
        feed(8'hFF, 1'b1);
        start_pkt();
        wait_done("byte_ff");

        // 0xFC: six trailing 1s force a stuffed bit in TAIL.
        push_byte_bits(8'h80);
        push_byte_bits(8'hFC);
        exp_ready.push_back(8);
        expect_pkt(137, 161, 17, 1, 0);
        feed(8'hFC, 1'b1);
        start_pkt();
        wait_done("byte_fc");

        // Underrun: nothing available at the end of SYNC.
        push_byte_bits(8'h80);
        expect_pkt(65, 89, 8, 0, 1);
        start_pkt();
        wait_done("underrun");
        check("error_sticky", int'(bus.tx_error), 1);

        // Abort with rst at cycle 50, then restart cleanly.
        sb_en = 1'b0;
        stray = 0;
        feed(8'h00, 1'b1);
        start_pkt();
        check("error_cleared", int'(bus.tx_error), 0);
        check("busy_after_start", int'(bus.tx_busy), 1);
        while ((cyc - t0) < 50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_bit", int'(bus.tx_out_bit), 1);
        check("abort_busy",    int'(bus.tx_busy), 0);
        check("abort_shift",   int'(bus.tx_shift), 0);
        check("abort_eop",     int'(bus.create_eop), 0);
        check("abort_done",    int'(bus.tx_done), 0);
        check("abort_error",   int'(bus.tx_error), 0);
        feed_data.delete();
        feed_last.delete();
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_stray_events", stray, 0);
        nshift = 0;
        nstuff = 0;
        sb_en  = 1'b1;
        pkt_single_00();

        check("final_bits_left", exp_bits.size(), 0);
        check("final_done_left", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
